// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack, downstream redirect,
// and the valid/ready instruction hand-off to decode.
interface fetch_unit_if #(
    parameter int unsigned addr_data_width = 32
);
    logic                       imem_req;
    logic [addr_data_width-1:0] imem_addr;
    logic                       imem_ack;
    logic [addr_data_width-1:0] imem_rdata;
    logic                       redirect_valid;
    logic [addr_data_width-1:0] redirect_pc;
    logic                       instr_valid;
    logic                       instr_ready;
    logic [addr_data_width-1:0] instr_out;
    logic [addr_data_width-1:0] instr_pc;

    modport master (
        output imem_req, imem_addr, instr_valid, instr_out, instr_pc,
        input  imem_ack, imem_rdata, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr_out, instr_pc,
        output imem_ack, imem_rdata, redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word at a time over req/ack,
// buffers it for decode, and squashes in-flight work on downstream redirects.
module fetch_unit #(
    parameter int unsigned                 addr_data_width = 32,
    parameter logic [addr_data_width-1:0] reset_pc        = '0
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  bus
);
    localparam int unsigned aw = addr_data_width;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state;
    logic [aw-1:0] pc;
    logic [aw-1:0] pending;
    logic [aw-1:0] target;

    // Redirect targets are word aligned; the low address bits are dropped.
    assign target        = bus.redirect_pc & ~aw'(3);
    assign bus.imem_addr = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= FETCH;
            pc              <= reset_pc;
            pending         <= '0;
            bus.imem_req    <= 1'b0;
            bus.instr_valid <= 1'b0;
            bus.instr_out   <= '0;
            bus.instr_pc    <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (bus.redirect_valid) begin
                        // Returned word (if any) is stale; a live request keeps going.
                        bus.imem_req <= 1'b1;
                        if (bus.imem_ack) begin
                            pc <= target;
                        end else begin
                            pending <= target;
                            state   <= DRAIN;
                        end
                    end else if (bus.imem_ack) begin
                        bus.instr_out   <= bus.imem_rdata;
                        bus.instr_pc    <= pc;
                        bus.instr_valid <= 1'b1;
                        bus.imem_req    <= 1'b0;
                        pc              <= pc + aw'(4);
                        state           <= HOLD;
                    end else begin
                        bus.imem_req <= 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.redirect_valid) begin
                        pc              <= target;
                        bus.instr_valid <= 1'b0;
                        bus.imem_req    <= 1'b1;
                        state           <= FETCH;
                    end else if (bus.instr_ready) begin
                        bus.instr_valid <= 1'b0;
                        bus.imem_req    <= 1'b1;
                        state           <= FETCH;
                    end
                end
                DRAIN: begin
                    // Hold the stale request until memory answers, then restart at the newest target.
                    if (bus.imem_ack) begin
                        pc    <= bus.redirect_valid ? target : pending;
                        state <= FETCH;
                    end else if (bus.redirect_valid) begin
                        pending <= target;
                    end
                end
                default: begin
                    state        <= FETCH;
                    bus.imem_req <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the single-cycle decode/execute datapath.
- Owns the program counter and issues word requests to instruction memory over a req/ack handshake with variable latency.
- Buffers one fetched instruction and its PC, and presents them to decode over a valid/ready handshake.
- Accepts redirects (branch/jump targets) from downstream, squashing any in-flight or buffered instruction.

Parameters:
addr_data_width, 32, width of PC, memory address and instruction word
reset_pc, 32'h0000_0000, PC value loaded on reset

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
imem_req  output  1  fetch request to instruction memory, held until imem_ack
imem_addr  output  addr_data_width  byte address of the requested word, stable while imem_req=1
imem_ack  input  1  one-cycle pulse: imem_rdata valid this cycle
imem_rdata  input  addr_data_width  instruction word returned by memory
redirect_valid  input  1  one-cycle redirect strobe from downstream
redirect_pc  input  addr_data_width  redirect target; bits [1:0] ignored and treated as 0
instr_valid  output  1  instr_out/instr_pc hold a valid instruction
instr_ready  input  1  decode accepts the instruction this cycle
instr_out  output  addr_data_width  buffered instruction word
instr_pc  output  addr_data_width  address instr_out was fetched from

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- All outputs are registered. imem_addr equals the current pc register.
- Reset values: pc=reset_pc, state=FETCH, imem_req=0, instr_valid=0, instr_out=0, instr_pc=0, pending target=0.
- First request: imem_req rises the cycle after reset deasserts.
- State FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ack with no redirect: instr_out<=imem_rdata, instr_pc<=pc, pc<=pc+4, instr_valid<=1, imem_req<=0, go to HOLD.
  - The memory must not ack in the same cycle req rises. Minimum issue-to-valid latency is 2 cycles.
- State HOLD:
  - imem_req=0, instr_valid=1. instr_out and instr_pc are stable until the handshake completes.
  - On instr_valid & instr_ready: instr_valid<=0, go to FETCH (imem_req=1 next cycle).
- State DRAIN (redirect arrived while a request was outstanding):
  - imem_req stays 1 and imem_addr keeps the old pc; the memory transaction is never abandoned.
  - On imem_ack: discard imem_rdata, pc<=pending target, go to FETCH.
- Redirect has priority over every other event in all states:
  - FETCH, no ack this cycle: latch redirect_pc&~3 as pending target, go to DRAIN.
  - FETCH, ack in the same cycle: discard rdata, pc<=redirect_pc&~3, stay in FETCH (imem_req remains 1 with the new address).
  - HOLD: pc<=redirect_pc&~3, instr_valid<=0, go to FETCH. If instr_ready is also high that cycle, the buffered instruction counts as consumed; decode owns that outcome.
  - DRAIN: pending target is overwritten; the newest redirect wins.
- PC arithmetic is modulo 2^addr_data_width: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.
- Reset mid-operation: any outstanding request is abandoned (imem_req=0 the cycle after reset is sampled) and the buffer is cleared. The memory must tolerate a dropped request on reset.
- instr_ready while instr_valid=0 has no effect.

Test Plan:
- Reset, memory acks 1 cycle after req with rdata=32'h0020_81B3 -> imem_addr=0x0, instr_valid=1 with instr_out=32'h0020_81B3, instr_pc=0x0. After the ready handshake, next imem_addr=0x4.
- instr_ready held 0 for 5 cycles in HOLD -> instr_valid stays 1, instr_out and instr_pc unchanged, imem_req=0 throughout. Ready=1 -> valid drops the next cycle.
- Redirect to 0x103 while a request to 0x8 is outstanding, ack 3 cycles later -> imem_addr stays 0x8 until ack, instr_valid stays 0, data discarded, next imem_addr=0x100.
- Redirect to 0x200 in HOLD with instr_pc=0x10 -> instr_valid=0 next cycle, next request addr=0x200, later instr_pc=0x200.
- reset_pc=32'hFFFF_FFFC, one fetch plus handshake -> instr_pc=0xFFFF_FFFC, next imem_addr=0x0000_0000.
- Two redirects (0x40, then 0x80) during DRAIN, then ack -> next imem_addr=0x80. Reset asserted mid-FETCH -> imem_req=0, instr_valid=0 the following cycle, pc=reset_pc.
